qpsk_tx_mapper: RTL and testbench
=================================

Name: qpsk_tx_mapper

Overview:
Transmit-side QPSK symbol mapper and upsampler for the modem.
- Accepts a serial bit stream over a valid/ready handshake and pairs the bits: first bit goes to I, second to Q.
- Maps each bit to ±AMP.
- Holds each symbol for SPS clock cycles, producing rectangular baseband I/Q samples for the shaping filter/DAC path.
- Emits sym_flag on the first sample of each symbol; bit 1 maps to a positive level, so the receiver's sign decision recovers the bit.

Parameters:
DW, 20, sample width of tx_I/tx_Q (signed two's complement)
SPS, 100, samples (clock cycles) per symbol, ≥2
AMP, 131071, magnitude of the mapped level, must be < 2^(DW-1)
PRE_SYMS, 32, preamble length in symbols (used only with QPSK_TX_PREAMBLE_EN)

Ports:
clk  in  1  sample clock
rst_n  in  1  asynchronous active-low reset
tx_en  in  1  transmit enable, level
bit_in  in  1  serial data bit
bit_valid  in  1  bit_in valid
bit_ready  out  1  mapper can accept a bit; equals ~pend_full
tx_I  out  DW  I baseband sample, registered
tx_Q  out  DW  Q baseband sample, registered
sym_flag  out  1  high on the first sample cycle of each transmitted symbol
busy  out  1  state != IDLE
underrun  out  1  one-cycle pulse when a symbol boundary finds no pair while tx_en=1

Behaviour:
- Reset (async, rst_n=0) clears all registers:
  - tx_I=tx_Q=0, sym_flag=0, underrun=0, busy=0, bit_ready=1.
  - phase=0, pend_full=0, samp_cnt=0, state=IDLE.
- Bit pairing:
  - A transfer occurs on bit_valid && bit_ready.
  - phase 0: store pend_I=bit_in, phase→1.
  - phase 1: store pend_Q=bit_in, pend_full→1, phase→0.
  - bit_ready=~pend_full, so there is no accept while full. One pending pair plus the symbol on air is the total buffering.
  - A partial pair (phase=1) survives tx_en toggles; only reset clears it.
- Mapping: bit 1 → +AMP, bit 0 → −AMP, sign-extended to DW.
- FSM states: IDLE, PRE (macro only), RUN.
- IDLE:
  - Outputs 0, samp_cnt=0.
  - If tx_en && pend_full: on the next edge, load the pair into tx_I/tx_Q, clear pend_full, sym_flag=1, samp_cnt=0, go to RUN.
  - Latency: pair complete → first sample on tx_I is 1 cycle when already enabled.
- RUN:
  - samp_cnt increments each cycle and wraps at SPS-1.
  - sym_flag=1 only in the cycle with samp_cnt=0.
  - At samp_cnt=SPS-1, with tx_en=1 and pend_full=1: load the next pair, consume it, sym_flag=1. Back-to-back symbols have no gap.
  - At samp_cnt=SPS-1, with tx_en=1 and pend_full=0: go to IDLE, outputs→0, underrun pulse 1 cycle.
  - At samp_cnt=SPS-1, with tx_en=0: go to IDLE, outputs→0, no underrun.
  - tx_en dropping mid-symbol never truncates a symbol; all SPS samples are sent.
- Simultaneous events: consume at a boundary and a bit transfer in the same cycle cannot collide (ready is low while full). A pair completing on the boundary cycle is not consumed until the next boundary.
- Reset mid-symbol: outputs return to 0 immediately (async).
- samp_cnt width is clog2(SPS). No arithmetic overflow is possible because levels are constants.

Optional Feature:
QPSK_TX_PREAMBLE_EN.
- Defined:
  - IDLE with tx_en=1 goes to PRE regardless of pend_full.
  - PRE emits PRE_SYMS symbols alternating (+AMP,+AMP),(−AMP,−AMP), starting with +, each SPS samples with sym_flag. This gives the receiver's timing-error detector a transition every symbol.
  - At the last PRE boundary, the RUN boundary rules apply: load data, or go to IDLE (with underrun if tx_en=1).
  - tx_en dropping during PRE completes the current symbol, then goes to IDLE.
  - The preamble symbol counter is clog2(PRE_SYMS+1) bits.
- Undefined: no PRE state and no preamble counter; behaviour is as above.

Decomposition:
- Shared package qpsk_pkg holds:
  - DW, SPS, and AMP defaults;
  - the state encoding (IDLE=0, PRE=1, RUN=2);
  - the mapping function bit→level.
- One sub-module, qpsk_bit_pairer, owns:
  - inputs bit_in/bit_valid and the consume strobe;
  - outputs bit_ready, pend_I, pend_Q, pend_full.
- The top holds the FSM, samp_cnt, and output registers.

Test Plan:
- Reset then tx_en=1, feed bits 1,0 → bit_ready low after the 2nd bit; next cycle tx_I=+131071, tx_Q=−131071, sym_flag=1 for exactly 1 cycle, values held 100 cycles.
- Continuous stream 11,00,01,10 with tx_en=1 → four contiguous 100-cycle symbols (+,+),(−,−),(−,+),(+,−); sym_flag every 100 cycles; no underrun.
- Starve after one pair → after 100 samples: tx_I=tx_Q=0, busy=0, underrun=1 for 1 cycle.
- Drop tx_en at sample 37 of a symbol with a pair pending → symbol runs to sample 99, then IDLE without underrun; pair retained; re-raising tx_en sends it.
- Assert rst_n=0 at sample 50 → outputs 0 immediately; bit_ready=1; phase cleared (next two bits form a fresh pair).
- With QPSK_TX_PREAMBLE_EN, PRE_SYMS=4, tx_en=1 and no data → (+,+),(−,−),(+,+),(−,−) at 100 cycles each, then IDLE with an underrun pulse.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared defaults, FSM state encoding and bit-to-level mapping for the QPSK transmit mapper.
package qpsk_pkg;

   localparam int DW_DEF  = 20;
   localparam int SPS_DEF = 100;
   localparam int AMP_DEF = 131071;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Bit 1 maps to the positive level so a sign slicer at the receiver recovers the bit.
   function automatic logic signed [31:0] map_level(input logic b, input int amp);
      return b ? 32'(amp) : -32'(amp);
   endfunction

endpackage

// File: rtl/qpsk_tx_mapper_if.sv
// Serial bit-stream valid/ready handshake feeding the QPSK transmit mapper.
interface qpsk_tx_mapper_if;

   logic bit_in;
   logic bit_valid;
   logic bit_ready;

   modport master (output bit_in, output bit_valid, input bit_ready);
   modport slave  (input bit_in, input bit_valid, output bit_ready);

endinterface

// File: rtl/qpsk_bit_pairer.sv
// Collects serial bits into (I,Q) pairs; holds one complete pair until the FSM consumes it.
module qpsk_bit_pairer (
   input  logic clk,
   input  logic rst_n,
   input  logic bit_in,
   input  logic bit_valid,
   input  logic consume,
   output logic bit_ready,
   output logic pend_i,
   output logic pend_q,
   output logic pend_full
);

   logic phase;
   logic xfer;

   assign bit_ready = ~pend_full;
   assign xfer      = bit_valid && bit_ready;

   // consume only happens while full and xfer only while not full, so they never coincide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= 1'b0;
         pend_i    <= 1'b0;
         pend_q    <= 1'b0;
         pend_full <= 1'b0;
      end else begin
         if (consume) begin
            pend_full <= 1'b0;
         end
         if (xfer) begin
            if (!phase) begin
               pend_i <= bit_in;
               phase  <= 1'b1;
            end else begin
               pend_q    <= bit_in;
               pend_full <= 1'b1;
               phase     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/qpsk_tx_mapper.sv
// QPSK symbol mapper and rectangular upsampler (SPS samples per symbol).
// Optional preamble of alternating symbols enabled by defining QPSK_TX_PREAMBLE_EN.
module qpsk_tx_mapper
   import qpsk_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int SPS = SPS_DEF,
   parameter int AMP = AMP_DEF
`ifdef QPSK_TX_PREAMBLE_EN
   ,
   parameter int PRE_SYMS = 32
`endif
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_en,
   qpsk_tx_mapper_if.slave      bus,
   output logic signed [DW-1:0] tx_I,
   output logic signed [DW-1:0] tx_Q,
   output logic                 sym_flag,
   output logic                 busy,
   output logic                 underrun
);

   localparam int CW = $clog2(SPS);

   state_t               state, state_nxt;
   logic [CW-1:0]        samp_cnt, cnt_nxt;
   logic signed [DW-1:0] i_nxt, q_nxt;
   logic                 flag_nxt, und_nxt;
   logic                 consume, do_load, do_stop, at_end;
   logic                 pend_i, pend_q, pend_full;
   logic signed [DW-1:0] lvl_i, lvl_q;

   qpsk_bit_pairer u_pairer (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_in    (bus.bit_in),
      .bit_valid (bus.bit_valid),
      .consume   (consume),
      .bit_ready (bus.bit_ready),
      .pend_i    (pend_i),
      .pend_q    (pend_q),
      .pend_full (pend_full)
   );

   assign lvl_i  = DW'(map_level(pend_i, AMP));
   assign lvl_q  = DW'(map_level(pend_q, AMP));
   assign at_end = (samp_cnt == CW'(SPS - 1));
   assign busy   = (state != ST_IDLE);

`ifdef QPSK_TX_PREAMBLE_EN
   localparam int PW = $clog2(PRE_SYMS + 1);

   // pre_cnt counts preamble symbols already started; even index is the + symbol
   logic [PW-1:0]        pre_cnt, pre_nxt;
   logic signed [DW-1:0] lvl_pre;

   assign lvl_pre = DW'(map_level(~pre_cnt[0], AMP));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pre_cnt <= '0;
      else        pre_cnt <= pre_nxt;
   end
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = samp_cnt;
      i_nxt     = tx_I;
      q_nxt     = tx_Q;
      flag_nxt  = 1'b0;
      und_nxt   = 1'b0;
      consume   = 1'b0;
      do_load   = 1'b0;
      do_stop   = 1'b0;
`ifdef QPSK_TX_PREAMBLE_EN
      pre_nxt   = pre_cnt;
`endif
      case (state)
         ST_IDLE: begin
            i_nxt   = '0;
            q_nxt   = '0;
            cnt_nxt = '0;
`ifdef QPSK_TX_PREAMBLE_EN
            if (tx_en) begin
               state_nxt = ST_PRE;
               i_nxt     = DW'(map_level(1'b1, AMP));
               q_nxt     = DW'(map_level(1'b1, AMP));
               flag_nxt  = 1'b1;
               pre_nxt   = PW'(1);
            end
`else
            if (tx_en && pend_full) do_load = 1'b1;
`endif
         end
`ifdef QPSK_TX_PREAMBLE_EN
         ST_PRE: begin
            if (!at_end) begin
               cnt_nxt = samp_cnt + CW'(1);
            end else if (!tx_en) begin
               do_stop = 1'b1;
            end else if (pre_cnt == PW'(PRE_SYMS)) begin
               if (pend_full) do_load = 1'b1;
               else           do_stop = 1'b1;
            end else begin
               cnt_nxt  = '0;
               i_nxt    = lvl_pre;
               q_nxt    = lvl_pre;
               flag_nxt = 1'b1;
               pre_nxt  = pre_cnt + PW'(1);
            end
         end
`endif
         ST_RUN: begin
            if (!at_end)                 cnt_nxt = samp_cnt + CW'(1);
            else if (tx_en && pend_full) do_load = 1'b1;
            else                         do_stop = 1'b1;
         end
         default: begin
            do_stop = 1'b1;
         end
      endcase

      // Symbol boundary actions shared by IDLE start, RUN and the end of the preamble
      if (do_load) begin
         state_nxt = ST_RUN;
         cnt_nxt   = '0;
         i_nxt     = lvl_i;
         q_nxt     = lvl_q;
         flag_nxt  = 1'b1;
         consume   = 1'b1;
      end
      if (do_stop) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
         i_nxt     = '0;
         q_nxt     = '0;
         und_nxt   = tx_en;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         samp_cnt <= '0;
         tx_I     <= '0;
         tx_Q     <= '0;
         sym_flag <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state    <= state_nxt;
         samp_cnt <= cnt_nxt;
         tx_I     <= i_nxt;
         tx_Q     <= q_nxt;
         sym_flag <= flag_nxt;
         underrun <= und_nxt;
      end
   end

endmodule

// File: tb/tb_qpsk_tx_mapper.sv
// Directed self-checking bench for qpsk_tx_mapper (SPS=100, AMP=131071).
module tb_qpsk_tx_mapper;

   localparam int DW  = 20;
   localparam int SPS = 100;
   localparam int AMP = 131071;

   logic                 clk;
   logic                 rst_n;
   logic                 tx_en;
   logic signed [DW-1:0] tx_I, tx_Q;
   logic                 sym_flag, busy, underrun;
   int                   n_pass = 0;
   int                   n_tot  = 0;

   qpsk_tx_mapper_if bus();

`ifdef QPSK_TX_PREAMBLE_EN
   qpsk_tx_mapper #(.DW(DW), .SPS(SPS), .AMP(AMP), .PRE_SYMS(4)) dut (
`else
   qpsk_tx_mapper #(.DW(DW), .SPS(SPS), .AMP(AMP)) dut (
`endif
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_en    (tx_en),
      .bus      (bus),
      .tx_I     (tx_I),
      .tx_Q     (tx_Q),
      .sym_flag (sym_flag),
      .busy     (busy),
      .underrun (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      logic rdy;
      logic done;
      done = 1'b0;
      bus.bit_in    = b;
      bus.bit_valid = 1'b1;
      for (int t = 0; t < 300 && !done; t++) begin
         rdy = bus.bit_ready;
         tick();
         if (rdy) done = 1'b1;
      end
      bus.bit_valid = 1'b0;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   // Entered one step after the symbol's first-sample edge; leaves one step after sample SPS-1.
   task automatic sym_check(input string tag, input int ei, input int eq, input int nb,
                            input logic b0, input logic b1, input int drop_at);
      int bad;
      chk({tag, "_I"}, tx_I, ei);
      chk({tag, "_Q"}, tx_Q, eq);
      chk({tag, "_flag"}, sym_flag, 1);
      chk({tag, "_busy"}, busy, 1);
      bad = 0;
      for (int k = 1; k < SPS; k++) begin
         bus.bit_valid = (nb == 2) && (k == 1 || k == 2);
         bus.bit_in    = (k == 1) ? b0 : b1;
         if (k == drop_at) tx_en = 1'b0;
         tick();
         if (tx_I !== DW'(ei) || tx_Q !== DW'(eq) || sym_flag !== 1'b0 || underrun !== 1'b0) bad++;
      end
      bus.bit_valid = 1'b0;
      chk({tag, "_hold"}, bad, 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      tx_en         = 1'b0;
      bus.bit_in    = 1'b0;
      bus.bit_valid = 1'b0;
      repeat (3) tick();
      chk("rst_I", tx_I, 0);
      chk("rst_Q", tx_Q, 0);
      chk("rst_flag", sym_flag, 0);
      chk("rst_und", underrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", bus.bit_ready, 1);
      rst_n = 1'b1;
      tick();

`ifdef QPSK_TX_PREAMBLE_EN
      tx_en = 1'b1;
      tick();
      sym_check("pre0", AMP, AMP, 0, 1'b0, 1'b0, 0);
      tick();
      sym_check("pre1", -AMP, -AMP, 0, 1'b0, 1'b0, 0);
      tick();
      sym_check("pre2", AMP, AMP, 0, 1'b0, 1'b0, 0);
      tick();
      sym_check("pre3", -AMP, -AMP, 0, 1'b0, 1'b0, 0);
      tick();
      tx_en = 1'b0;
      chk("pre_end_und", underrun, 1);
      chk("pre_end_busy", busy, 0);
      chk("pre_end_I", tx_I, 0);
      chk("pre_end_Q", tx_Q, 0);
`else
      // single pair 1,0 with transmitter already enabled, then starvation
      tx_en = 1'b1;
      send_bit(1'b1);
      chk("t1_ready_half", bus.bit_ready, 1);
      send_bit(1'b0);
      chk("t1_ready_full", bus.bit_ready, 0);
      chk("t1_I_before", tx_I, 0);
      tick();
      sym_check("t1", AMP, -AMP, 0, 1'b0, 1'b0, 0);
      tick();
      chk("t1_starve_I", tx_I, 0);
      chk("t1_starve_Q", tx_Q, 0);
      chk("t1_starve_busy", busy, 0);
      chk("t1_starve_und", underrun, 1);
      tick();
      chk("t1_und_pulse", underrun, 0);

      // contiguous stream 11,00,01,10
      tx_en = 1'b0;
      send_bit(1'b1);
      send_bit(1'b1);
      chk("t2_idle_busy", busy, 0);
      chk("t2_idle_ready", bus.bit_ready, 0);
      tx_en = 1'b1;
      tick();
      sym_check("t2_s0", AMP, AMP, 2, 1'b0, 1'b0, 0);
      tick();
      sym_check("t2_s1", -AMP, -AMP, 2, 1'b0, 1'b1, 0);
      tick();
      sym_check("t2_s2", -AMP, AMP, 2, 1'b1, 1'b0, 0);
      tick();
      sym_check("t2_s3", AMP, -AMP, 0, 1'b0, 1'b0, 0);
      tick();
      chk("t2_end_und", underrun, 1);
      chk("t2_end_busy", busy, 0);

      // tx_en dropped mid-symbol with a pair pending
      tx_en = 1'b0;
      send_bit(1'b0);
      send_bit(1'b1);
      tx_en = 1'b1;
      tick();
      sym_check("t4_s0", -AMP, AMP, 2, 1'b1, 1'b1, 37);
      tick();
      chk("t4_stop_busy", busy, 0);
      chk("t4_stop_und", underrun, 0);
      chk("t4_stop_I", tx_I, 0);
      chk("t4_retained", bus.bit_ready, 0);
      repeat (5) tick();
      chk("t4_still_idle", busy, 0);
      tx_en = 1'b1;
      tick();
      sym_check("t4_s1", AMP, AMP, 0, 1'b0, 1'b0, 0);
      tick();
      chk("t4_end_und", underrun, 1);

      // reset mid-symbol with a half pair captured
      tx_en = 1'b0;
      send_bit(1'b1);
      send_bit(1'b0);
      tx_en = 1'b1;
      tick();
      chk("t5_I", tx_I, AMP);
      chk("t5_Q", tx_Q, -AMP);
      bus.bit_in    = 1'b1;
      bus.bit_valid = 1'b1;
      tick();
      bus.bit_valid = 1'b0;
      repeat (49) tick();
      rst_n = 1'b0;
      tx_en = 1'b0;
      #1;
      chk("t5_rst_I", tx_I, 0);
      chk("t5_rst_Q", tx_Q, 0);
      chk("t5_rst_flag", sym_flag, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_ready", bus.bit_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      send_bit(1'b0);
      send_bit(1'b1);
      tx_en = 1'b1;
      tick();
      sym_check("t5_fresh", -AMP, AMP, 0, 1'b0, 1'b0, 0);
      tick();
      chk("t5_end_und", underrun, 1);
      tx_en = 1'b0;
`endif

      tick();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
